// File: rtl/respawn_ctrl.sv
// respawn_ctrl: round/respawn controller tracking right-of-way, respawn positions,
// goals and the match winner downstream of the per-player death timers.
module respawn_ctrl #(
    parameter int X_W        = 11,
    parameter int SCREEN_W   = 1024,
    parameter int OFFSET     = 300,
    parameter int P1_START   = 300,
    parameter int P2_START   = 724,
    parameter int ROUND_HOLD = 1000,
    parameter int WIN_SCORE  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           death_p1_i,
    input  logic           death_p2_i,
    input  logic [X_W-1:0] p1_x_i,
    input  logic [X_W-1:0] p2_x_i,
    input  logic           p1_at_goal_i,
    input  logic           p2_at_goal_i,
    input  logic           new_game_i,
    output logic           respawn_p1_o,
    output logic           respawn_p2_o,
    output logic [X_W-1:0] spawn_x_p1_o,
    output logic [X_W-1:0] spawn_x_p2_o,
    output logic [1:0]     row_o,
    output logic           timer_abort_o,
    output logic [3:0]     score_p1_o,
    output logic [3:0]     score_p2_o,
    output logic           game_over_o,
    output logic           winner_o
);
    localparam int CW = $clog2(ROUND_HOLD + 1);

    typedef enum logic [2:0] {FIGHT, P1_DEAD, P2_DEAD, BOTH_DEAD, ROUND_END, GAME_OVER} state_t;

    state_t         state_q, state_d;
    logic           d1_q, d2_q, seen1_q, seen1_d, seen2_q, seen2_d;
    logic           r1_q, r1_d, r2_q, r2_d, restart;
    logic [X_W-1:0] kx_q, kx_d, x1_q, x1_d, x2_q, x2_d;
    logic [1:0]     row_q, row_d;
    logic [3:0]     s1_q, s1_d, s2_q, s2_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rise1, rise2, fall1, fall2, won;
    logic [X_W:0]   fwd;
    logic [X_W-1:0] bwd;

    assign rise1 = death_p1_i & ~d1_q;
    assign rise2 = death_p2_i & ~d2_q;
    assign fall1 = ~death_p1_i & d1_q;
    assign fall2 = ~death_p2_i & d2_q;
    // one extra bit so kx+OFFSET cannot wrap before the clamp
    assign fwd   = {1'b0, kx_q} + (X_W+1)'(OFFSET);
    assign bwd   = (kx_q < X_W'(OFFSET)) ? '0 : kx_q - X_W'(OFFSET);
    assign won   = (s1_q == 4'(WIN_SCORE)) || (s2_q == 4'(WIN_SCORE));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        kx_d    = kx_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        seen1_d = seen1_q;
        seen2_d = seen2_q;
        r1_d    = 1'b0;
        r2_d    = 1'b0;
        x1_d    = x1_q;
        x2_d    = x2_q;
        restart = 1'b0;
        case (state_q)
            FIGHT: begin
                if (rise1 && rise2) begin
                    row_d   = 2'b00;
                    seen1_d = 1'b0;
                    seen2_d = 1'b0;
                    state_d = BOTH_DEAD;
                end else if (rise1) begin
                    row_d   = 2'b10;
                    kx_d    = p2_x_i;
                    state_d = P1_DEAD;
                end else if (rise2) begin
                    row_d   = 2'b01;
                    kx_d    = p1_x_i;
                    state_d = P2_DEAD;
                end else if (p1_at_goal_i && row_q == 2'b01) begin
                    s1_d    = (s1_q < 4'(WIN_SCORE)) ? s1_q + 4'd1 : s1_q;
                    cnt_d   = '0;
                    state_d = ROUND_END;
                end else if (p2_at_goal_i && row_q == 2'b10) begin
                    s2_d    = (s2_q < 4'(WIN_SCORE)) ? s2_q + 4'd1 : s2_q;
                    cnt_d   = '0;
                    state_d = ROUND_END;
                end
            end
            P1_DEAD: begin
                if (fall1) begin
                    r1_d    = 1'b1;
                    x1_d    = bwd;
                    state_d = FIGHT;
                end
            end
            P2_DEAD: begin
                if (fall2) begin
                    r2_d    = 1'b1;
                    x2_d    = (fwd > (X_W+1)'(SCREEN_W-1)) ? X_W'(SCREEN_W-1) : fwd[X_W-1:0];
                    state_d = FIGHT;
                end
            end
            BOTH_DEAD: begin
                seen1_d = seen1_q | fall1;
                seen2_d = seen2_q | fall2;
                restart = seen1_d & seen2_d;
            end
            ROUND_END: begin
                if (cnt_q == CW'(ROUND_HOLD-1)) begin
                    state_d = won ? GAME_OVER : state_q;
                    restart = ~won;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAME_OVER: begin
                if (new_game_i) begin
                    s1_d    = '0;
                    s2_d    = '0;
                    restart = 1'b1;
                end
            end
            default: state_d = FIGHT;
        endcase
        if (restart) begin
            r1_d    = 1'b1;
            r2_d    = 1'b1;
            x1_d    = X_W'(P1_START);
            x2_d    = X_W'(P2_START);
            row_d   = 2'b00;
            state_d = FIGHT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIGHT;
            d1_q    <= 1'b0;
            d2_q    <= 1'b0;
            seen1_q <= 1'b0;
            seen2_q <= 1'b0;
            r1_q    <= 1'b0;
            r2_q    <= 1'b0;
            kx_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            row_q   <= 2'b00;
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            d1_q    <= death_p1_i;
            d2_q    <= death_p2_i;
            seen1_q <= seen1_d;
            seen2_q <= seen2_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            kx_q    <= kx_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            row_q   <= row_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign respawn_p1_o  = r1_q;
    assign respawn_p2_o  = r2_q;
    assign spawn_x_p1_o  = x1_q;
    assign spawn_x_p2_o  = x2_q;
    assign row_o         = row_q;
    assign score_p1_o    = s1_q;
    assign score_p2_o    = s2_q;
    assign timer_abort_o = (state_q == ROUND_END) || (state_q == GAME_OVER);
    assign game_over_o   = state_q == GAME_OVER;
    assign winner_o      = s2_q == 4'(WIN_SCORE);
endmodule
